// File: rtl/int_rs_cdb_pkg.sv
// ============================================================================
// Module : int_rs_cdb_pkg
// Brief  : Shared constants and helpers for the integer reservation station.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package int_rs_cdb_pkg;

    localparam int         c_DATA_W  = 32;

    localparam logic [2:0] c_OP_ALU  = 3'd1;
    localparam logic [2:0] c_OP_BNE  = 3'd2;

    localparam logic [2:0] c_SUB_ADD = 3'd0;
    localparam logic [2:0] c_SUB_SUB = 3'd1;
    localparam logic [2:0] c_SUB_AND = 3'd2;
    localparam logic [2:0] c_SUB_OR  = 3'd3;
    localparam logic [2:0] c_SUB_XOR = 3'd4;

    // A source tag is pending when its bit at position tag_w (the MSB) is set.
    function automatic logic tag_pending(input logic [15:0] q, input int unsigned tag_w);
        return |(q >> tag_w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/int_rs_cdb_rs_operand.sv
// ============================================================================
// Module : rs_operand
// Brief  : One tagged operand slot; loads at issue, captures from two buses.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_operand
    import int_rs_cdb_pkg::*;
#(
    parameter int ROB_W  = 3,
    parameter int DATA_W = c_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    input  logic              busy,
    input  logic              load,
    input  logic              load_pend,
    input  logic [ROB_W-1:0]  load_tag,
    input  logic [DATA_W-1:0] load_data,
    input  logic              a_valid,
    input  logic [ROB_W-1:0]  a_tag,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    input  logic [ROB_W-1:0]  b_tag,
    input  logic [DATA_W-1:0] b_data,
    output logic              ready,
    output logic [DATA_W-1:0] data
);

    logic              r_ready;
    logic [ROB_W-1:0]  r_tag;
    logic [DATA_W-1:0] r_data;

    logic w_a_hit_ld;
    logic w_b_hit_ld;
    logic w_a_hit;
    logic w_b_hit;

    assign w_a_hit_ld = a_valid && (a_tag == load_tag);
    assign w_b_hit_ld = b_valid && (b_tag == load_tag);
    assign w_a_hit    = a_valid && (a_tag == r_tag);
    assign w_b_hit    = b_valid && (b_tag == r_tag);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ready <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (clr) begin
            r_ready <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (load) begin
            r_tag <= load_tag;
            if (!load_pend) begin
                r_ready <= 1'b1;
                r_data  <= load_data;
            end else if (w_a_hit_ld) begin
                r_ready <= 1'b1;
                r_data  <= a_data;
            end else if (w_b_hit_ld) begin
                r_ready <= 1'b1;
                r_data  <= b_data;
            end else begin
                r_ready <= 1'b0;
            end
        end else if (busy && !r_ready) begin
            if (w_a_hit) begin
                r_ready <= 1'b1;
                r_data  <= a_data;
            end else if (w_b_hit) begin
                r_ready <= 1'b1;
                r_data  <= b_data;
            end
        end
    end

    assign ready = r_ready;
    assign data  = r_data;

endmodule

`default_nettype wire

// File: rtl/int_rs_cdb.sv
// ============================================================================
// Module : int_rs_cdb
// Brief  : Integer RS (ALU + BNE) with CDB snoop and registered ALU CDB.
//          Optional macro ALU_SUB_EN enables the SUB subtype.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_rs_cdb
    import int_rs_cdb_pkg::*;
#(
    parameter int ROB_W = 3,
    parameter int ADD_N = 4,
    parameter int BNE_N = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             issue_valid,
    input  logic [2:0]       issue_type,
    input  logic [2:0]       issue_subtype,
    input  logic             issue_imm,
    input  logic [ROB_W-1:0] issue_rob,
    input  logic [31:0]      issue_d1,
    input  logic [31:0]      issue_d2,
    input  logic [ROB_W:0]   issue_q1,
    input  logic [ROB_W:0]   issue_q2,
    input  logic             cdb2_valid,
    input  logic [ROB_W-1:0] cdb2_rob,
    input  logic [31:0]      cdb2_data,
    output logic             add_free,
    output logic             bne_free,
    output logic             cdb_valid,
    output logic [ROB_W-1:0] cdb_rob,
    output logic [31:0]      cdb_data,
    output logic             bne_valid,
    output logic [ROB_W-1:0] bne_rob,
    output logic             bne_taken
);

    localparam int c_AI_W = (ADD_N > 1) ? $clog2(ADD_N) : 1;
    localparam int c_BI_W = (BNE_N > 1) ? $clog2(BNE_N) : 1;

    function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] v_res;
        case (op)
            c_SUB_ADD: v_res = a + b;
`ifdef ALU_SUB_EN
            c_SUB_SUB: v_res = a - b;
`endif
            c_SUB_AND: v_res = a & b;
            c_SUB_OR:  v_res = a | b;
            c_SUB_XOR: v_res = a ^ b;
            default:   v_res = '0;
        endcase
        return v_res;
    endfunction

    logic w_q1_pend;
    logic w_q2_pend;
    assign w_q1_pend = tag_pending(16'(issue_q1), ROB_W);
    assign w_q2_pend = !issue_imm && tag_pending(16'(issue_q2), ROB_W);

    logic [ADD_N-1:0]             r_add_busy;
    logic [ADD_N-1:0][2:0]        r_add_op;
    logic [ADD_N-1:0][ROB_W-1:0]  r_add_rob;
    logic [ADD_N-1:0]             w_add_rdy1, w_add_rdy2, w_add_load;
    logic [ADD_N-1:0][31:0]       w_add_d1, w_add_d2;
    logic                         w_add_wr, w_add_free_hit, w_add_disp_hit;
    logic [c_AI_W-1:0]            w_add_free_idx, w_add_disp_idx;

    logic [BNE_N-1:0]             r_bne_busy;
    logic [BNE_N-1:0][ROB_W-1:0]  r_bne_rob;
    logic [BNE_N-1:0]             w_bne_rdy1, w_bne_rdy2, w_bne_load;
    logic [BNE_N-1:0][31:0]       w_bne_d1, w_bne_d2;
    logic                         w_bne_wr, w_bne_free_hit, w_bne_disp_hit;
    logic [c_BI_W-1:0]            w_bne_free_idx, w_bne_disp_idx;

    // Descending scans so the lowest matching index wins.
    always_comb begin
        w_add_free_hit = 1'b0;
        w_add_free_idx = '0;
        w_add_disp_hit = 1'b0;
        w_add_disp_idx = '0;
        for (int i = ADD_N - 1; i >= 0; i--) begin
            if (!r_add_busy[i]) begin
                w_add_free_hit = 1'b1;
                w_add_free_idx = c_AI_W'(i);
            end
            if (r_add_busy[i] && w_add_rdy1[i] && w_add_rdy2[i]) begin
                w_add_disp_hit = 1'b1;
                w_add_disp_idx = c_AI_W'(i);
            end
        end
    end

    always_comb begin
        w_bne_free_hit = 1'b0;
        w_bne_free_idx = '0;
        w_bne_disp_hit = 1'b0;
        w_bne_disp_idx = '0;
        for (int i = BNE_N - 1; i >= 0; i--) begin
            if (!r_bne_busy[i]) begin
                w_bne_free_hit = 1'b1;
                w_bne_free_idx = c_BI_W'(i);
            end
            if (r_bne_busy[i] && w_bne_rdy1[i] && w_bne_rdy2[i]) begin
                w_bne_disp_hit = 1'b1;
                w_bne_disp_idx = c_BI_W'(i);
            end
        end
    end

    assign w_add_wr = issue_valid && (issue_type == c_OP_ALU) && w_add_free_hit && !flush;
    assign w_bne_wr = issue_valid && (issue_type == c_OP_BNE) && w_bne_free_hit && !flush;
    assign add_free = ~&r_add_busy;
    assign bne_free = ~&r_bne_busy;

    for (genvar i = 0; i < ADD_N; i++) begin : g_add
        assign w_add_load[i] = w_add_wr && (w_add_free_idx == c_AI_W'(i));
        rs_operand #(.ROB_W(ROB_W), .DATA_W(32)) u_op1 (
            .clock(clock), .reset(reset), .clr(flush), .busy(r_add_busy[i]),
            .load(w_add_load[i]), .load_pend(w_q1_pend),
            .load_tag(issue_q1[ROB_W-1:0]), .load_data(issue_d1),
            .a_valid(cdb_valid), .a_tag(cdb_rob), .a_data(cdb_data),
            .b_valid(cdb2_valid), .b_tag(cdb2_rob), .b_data(cdb2_data),
            .ready(w_add_rdy1[i]), .data(w_add_d1[i])
        );
        rs_operand #(.ROB_W(ROB_W), .DATA_W(32)) u_op2 (
            .clock(clock), .reset(reset), .clr(flush), .busy(r_add_busy[i]),
            .load(w_add_load[i]), .load_pend(w_q2_pend),
            .load_tag(issue_q2[ROB_W-1:0]), .load_data(issue_d2),
            .a_valid(cdb_valid), .a_tag(cdb_rob), .a_data(cdb_data),
            .b_valid(cdb2_valid), .b_tag(cdb2_rob), .b_data(cdb2_data),
            .ready(w_add_rdy2[i]), .data(w_add_d2[i])
        );
    end

    for (genvar i = 0; i < BNE_N; i++) begin : g_bne
        assign w_bne_load[i] = w_bne_wr && (w_bne_free_idx == c_BI_W'(i));
        rs_operand #(.ROB_W(ROB_W), .DATA_W(32)) u_op1 (
            .clock(clock), .reset(reset), .clr(flush), .busy(r_bne_busy[i]),
            .load(w_bne_load[i]), .load_pend(w_q1_pend),
            .load_tag(issue_q1[ROB_W-1:0]), .load_data(issue_d1),
            .a_valid(cdb_valid), .a_tag(cdb_rob), .a_data(cdb_data),
            .b_valid(cdb2_valid), .b_tag(cdb2_rob), .b_data(cdb2_data),
            .ready(w_bne_rdy1[i]), .data(w_bne_d1[i])
        );
        rs_operand #(.ROB_W(ROB_W), .DATA_W(32)) u_op2 (
            .clock(clock), .reset(reset), .clr(flush), .busy(r_bne_busy[i]),
            .load(w_bne_load[i]), .load_pend(w_q2_pend),
            .load_tag(issue_q2[ROB_W-1:0]), .load_data(issue_d2),
            .a_valid(cdb_valid), .a_tag(cdb_rob), .a_data(cdb_data),
            .b_valid(cdb2_valid), .b_tag(cdb2_rob), .b_data(cdb2_data),
            .ready(w_bne_rdy2[i]), .data(w_bne_d2[i])
        );
    end

    // Dispatch and issue never target the same entry: issue only picks idle ones.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_add_busy <= '0;
            r_add_op   <= '0;
            r_add_rob  <= '0;
            r_bne_busy <= '0;
            r_bne_rob  <= '0;
        end else if (flush) begin
            r_add_busy <= '0;
            r_bne_busy <= '0;
        end else begin
            if (w_add_disp_hit) r_add_busy[w_add_disp_idx] <= 1'b0;
            if (w_add_wr) begin
                r_add_busy[w_add_free_idx] <= 1'b1;
                r_add_op[w_add_free_idx]   <= issue_subtype;
                r_add_rob[w_add_free_idx]  <= issue_rob;
            end
            if (w_bne_disp_hit) r_bne_busy[w_bne_disp_idx] <= 1'b0;
            if (w_bne_wr) begin
                r_bne_busy[w_bne_free_idx] <= 1'b1;
                r_bne_rob[w_bne_free_idx]  <= issue_rob;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb_valid <= 1'b0;
            cdb_rob   <= '0;
            cdb_data  <= '0;
            bne_valid <= 1'b0;
            bne_rob   <= '0;
            bne_taken <= 1'b0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
            cdb_rob   <= '0;
            cdb_data  <= '0;
            bne_valid <= 1'b0;
            bne_rob   <= '0;
            bne_taken <= 1'b0;
        end else begin
            cdb_valid <= w_add_disp_hit;
            if (w_add_disp_hit) begin
                cdb_rob  <= r_add_rob[w_add_disp_idx];
                cdb_data <= alu(r_add_op[w_add_disp_idx], w_add_d1[w_add_disp_idx], w_add_d2[w_add_disp_idx]);
            end
            bne_valid <= w_bne_disp_hit;
            if (w_bne_disp_hit) begin
                bne_rob   <= r_bne_rob[w_bne_disp_idx];
                bne_taken <= (w_bne_d1[w_bne_disp_idx] != w_bne_d2[w_bne_disp_idx]);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_int_rs_cdb.sv
// ============================================================================
// Module : tb_int_rs_cdb
// Brief  : Directed and randomized checks of int_rs_cdb against a reference.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_int_rs_cdb;

    logic        clock, reset, flush;
    logic        issue_valid, issue_imm;
    logic [2:0]  issue_type, issue_subtype, issue_rob;
    logic [31:0] issue_d1, issue_d2;
    logic [3:0]  issue_q1, issue_q2;
    logic        cdb2_valid;
    logic [2:0]  cdb2_rob;
    logic [31:0] cdb2_data;
    logic        add_free, bne_free, cdb_valid, bne_valid, bne_taken;
    logic [2:0]  cdb_rob, bne_rob;
    logic [31:0] cdb_data;

    int errors = 0;
    int checks = 0;

    int_rs_cdb #(.ROB_W(3), .ADD_N(4), .BNE_N(2)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_subtype(issue_subtype),
        .issue_imm(issue_imm), .issue_rob(issue_rob), .issue_d1(issue_d1), .issue_d2(issue_d2),
        .issue_q1(issue_q1), .issue_q2(issue_q2),
        .cdb2_valid(cdb2_valid), .cdb2_rob(cdb2_rob), .cdb2_data(cdb2_data),
        .add_free(add_free), .bne_free(bne_free),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_data(cdb_data),
        .bne_valid(bne_valid), .bne_rob(bne_rob), .bne_taken(bne_taken)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference ALU semantics taken directly from the op table.
    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
`ifdef ALU_SUB_EN
            3'd1: return a - b;
`endif
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic iss(input logic [2:0] ty, input logic [2:0] st, input logic imm, input logic [2:0] rob,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [3:0] q1, input logic [3:0] q2);
        issue_valid   = 1'b1;
        issue_type    = ty;
        issue_subtype = st;
        issue_imm     = imm;
        issue_rob     = rob;
        issue_d1      = d1;
        issue_d2      = d2;
        issue_q1      = q1;
        issue_q2      = q2;
    endtask

    task automatic idle;
        issue_valid = 1'b0;
        issue_type  = 3'd0;
    endtask

    logic        exp_v, nxt_v;
    logic [2:0]  exp_rob, nxt_rob;
    logic [31:0] exp_data, nxt_data;

    initial begin
        reset = 1'b0; flush = 1'b0; idle();
        issue_subtype = 0; issue_imm = 0; issue_rob = 0; issue_d1 = 0; issue_d2 = 0;
        issue_q1 = 0; issue_q2 = 0; cdb2_valid = 0; cdb2_rob = 0; cdb2_data = 0;
        tick(); tick();
        chk("rst_cdb_valid", cdb_valid, 0);
        chk("rst_cdb_rob", cdb_rob, 0);
        chk("rst_cdb_data", cdb_data, 0);
        chk("rst_bne_valid", bne_valid, 0);
        chk("rst_bne_taken", bne_taken, 0);
        chk("rst_add_free", add_free, 1);
        chk("rst_bne_free", bne_free, 1);
        reset = 1'b1;
        tick();

        // Ready-at-issue ADD
        iss(3'd1, 3'd0, 0, 3'd3, 32'd5, 32'd7, 4'b0000, 4'b0000);
        tick(); idle();
        chk("rai_not_yet", cdb_valid, 0);
        tick();
        chk("rai_valid", cdb_valid, 1);
        chk("rai_rob", cdb_rob, 3);
        chk("rai_data", cdb_data, 12);
        chk("rai_free", add_free, 1);
        tick();
        chk("rai_pulse", cdb_valid, 0);

        // Pending operand, captured from the load bus
        iss(3'd1, 3'd4, 0, 3'd1, 32'd0, 32'd6, 4'b1010, 4'b0000);
        tick(); idle();
        cdb2_valid = 1; cdb2_rob = 3'd2; cdb2_data = 32'd9;
        tick();
        cdb2_valid = 0;
        chk("pend_bubble", cdb_valid, 0);
        tick();
        chk("pend_valid", cdb_valid, 1);
        chk("pend_rob", cdb_rob, 1);
        chk("pend_data", cdb_data, 15);
        tick();

        // Issue-time bypass from the ALU CDB
        iss(3'd1, 3'd0, 0, 3'd4, 32'h0000_000F, 32'd0, 4'b0000, 4'b0000);
        tick(); idle();
        tick();
        chk("byp_src_valid", cdb_valid, 1);
        chk("byp_src_rob", cdb_rob, 4);
        iss(3'd1, 3'd2, 0, 3'd5, 32'd0, 32'h3C, 4'b1100, 4'b0000);
        tick(); idle();
        tick();
        chk("byp_valid", cdb_valid, 1);
        chk("byp_rob", cdb_rob, 5);
        chk("byp_data", cdb_data, 32'h0C);
        tick();

        // BNE equal / not equal
        iss(3'd2, 3'd0, 0, 3'd2, 32'd3, 32'd3, 4'b0000, 4'b0000);
        tick();
        iss(3'd2, 3'd0, 0, 3'd3, 32'd3, 32'd4, 4'b0000, 4'b0000);
        tick(); idle();
        chk("bne0_valid", bne_valid, 1);
        chk("bne0_rob", bne_rob, 2);
        chk("bne0_taken", bne_taken, 0);
        tick();
        chk("bne1_valid", bne_valid, 1);
        chk("bne1_rob", bne_rob, 3);
        chk("bne1_taken", bne_taken, 1);
        tick();
        chk("bne_pulse", bne_valid, 0);

        // Full ALU station: fifth issue is dropped
        for (int i = 0; i < 5; i++) begin
            iss(3'd1, 3'd0, 1, 3'(i), 32'd0, 32'(16 * i), 4'b1111, 4'b0000);
            tick();
            if (i == 2) chk("full_free3", add_free, 1);
            if (i == 3) chk("full_free4", add_free, 0);
        end
        idle();
        chk("full_free5", add_free, 0);
        cdb2_valid = 1; cdb2_rob = 3'd7; cdb2_data = 32'd1;
        tick();
        cdb2_valid = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("full_valid", cdb_valid, 1);
            chk("full_rob", cdb_rob, 32'(k));
            chk("full_data", cdb_data, 32'(1 + 16 * k));
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("full_drop", cdb_valid, 0);
        end
        chk("full_free_end", add_free, 1);

        // Flush with three busy entries
        iss(3'd1, 3'd0, 0, 3'd1, 32'd0, 32'd1, 4'b1110, 4'b0000);
        tick();
        iss(3'd2, 3'd0, 0, 3'd2, 32'd0, 32'd1, 4'b1110, 4'b0000);
        tick();
        iss(3'd2, 3'd0, 0, 3'd3, 32'd0, 32'd1, 4'b1110, 4'b0000);
        tick(); idle();
        chk("fl_bne_full", bne_free, 0);
        flush = 1; cdb2_valid = 1; cdb2_rob = 3'd6; cdb2_data = 32'd5;
        tick();
        flush = 0; cdb2_valid = 0;
        chk("fl_add_free", add_free, 1);
        chk("fl_bne_free", bne_free, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fl_no_cdb", cdb_valid, 0);
            chk("fl_no_bne", bne_valid, 0);
        end

        // Random ready-at-issue ALU ops, back-to-back
        exp_v = 0; exp_rob = 0; exp_data = 0;
        for (int j = 0; j < 40; j++) begin
            nxt_v = ($urandom_range(0, 3) != 0);
            nxt_rob = 3'($urandom_range(0, 7));
            if (nxt_v) begin
                iss(3'd1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), nxt_rob,
                    $urandom, $urandom, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
                if (!issue_imm && issue_q2[3]) issue_q2 = 4'b0000;
                nxt_data = ref_alu(issue_subtype, issue_d1, issue_d2);
            end else begin
                idle();
                nxt_data = 0;
            end
            tick();
            chk("rnd_valid", cdb_valid, exp_v);
            if (exp_v) begin
                chk("rnd_rob", cdb_rob, exp_rob);
                chk("rnd_data", cdb_data, exp_data);
            end
            exp_v = nxt_v; exp_rob = nxt_rob; exp_data = nxt_data;
        end
        idle();
        tick();
        chk("rnd_last_valid", cdb_valid, exp_v);
        if (exp_v) chk("rnd_last_data", cdb_data, exp_data);

        // Asynchronous reset mid-cycle
        iss(3'd1, 3'd3, 0, 3'd6, 32'hF0, 32'h0F, 4'b0000, 4'b0000);
        tick(); idle();
        iss(3'd2, 3'd0, 0, 3'd5, 32'd1, 32'd2, 4'b0000, 4'b0000);
        tick(); idle();
        chk("ar_pre_valid", cdb_valid, 1);
        chk("ar_pre_data", cdb_data, 32'hFF);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_cdb_valid", cdb_valid, 0);
        chk("ar_cdb_rob", cdb_rob, 0);
        chk("ar_cdb_data", cdb_data, 0);
        chk("ar_add_free", add_free, 1);
        chk("ar_bne_free", bne_free, 1);
        tick();
        reset = 1'b1;
        tick();
        chk("ar_after_bne", bne_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/int_rs_cdb.md
# int_rs_cdb

Integer reservation-station block for the Tomasulo core. It holds ALU ops and BNE compares issued from decode. It snoops the load CDB and its own result bus for pending ROB tags, executes one ready ALU op per cycle, and drives the ALU common data bus. It also reports one resolved BNE per cycle to the reorder buffer.

## Interface
Parameters:
- `ROB_W`, default 3: ROB tag width.
- `ADD_N`, default 4: ALU entries.
- `BNE_N`, default 2: BNE entries.

Ports (name, direction, width, meaning):
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low; clears all state.
- `flush` in 1: synchronous ROB flush; clears all entries and outputs.
- `issue_valid` in 1: issue strobe from decode.
- `issue_type` in 3: 1 = ALU, 2 = BNE; any other value is ignored.
- `issue_subtype` in 3: ALU op code.
- `issue_imm` in 1: when set, operand 2 is `issue_d2` and `issue_q2` is ignored.
- `issue_rob` in ROB_W: destination ROB tag.
- `issue_d1`, `issue_d2` in 32: operand values.
- `issue_q1`, `issue_q2` in ROB_W+1: MSB set means pending; low bits are the producing tag.
- `cdb2_valid` in 1, `cdb2_rob` in ROB_W, `cdb2_data` in 32: load CDB.
- `add_free` out 1: at least one ALU entry is free.
- `bne_free` out 1: at least one BNE entry is free.
- `cdb_valid` out 1, `cdb_rob` out ROB_W, `cdb_data` out 32: ALU CDB, registered.
- `bne_valid` out 1, `bne_rob` out ROB_W, `bne_taken` out 1: BNE result, registered.

## Operation
- Issue:
  - An ALU or BNE issue with `issue_valid` high writes the lowest-index free entry of the matching station.
  - An issue to a full station is dropped; upstream must check `add_free`/`bne_free`.
- Issue-time bypass: if a pending `issue_q` tag matches `cdb_rob` (while `cdb_valid`) or `cdb2_rob` (while `cdb2_valid`) in the same cycle, the entry stores that bus's data as ready.
- Snoop: every busy entry with a pending operand compares it against both buses each cycle and captures matching data at the edge.
- ALU subtypes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - Results are 32-bit modulo; overflow is ignored.
  - Undefined subtypes yield 0.
- ALU dispatch: the lowest-index busy entry with both operands ready is executed. Its result is registered onto the CDB and the entry is freed at the same edge.
- BNE dispatch: the lowest-index ready BNE entry produces `bne_taken = (d1 != d2)` registered, then the entry frees.
- Free flags are combinational from the current busy bits. They do not account for same-cycle issue or dispatch.

## Timing
- Reset values: all entries free; `cdb_valid=0`, `bne_valid=0`; `cdb_rob`, `cdb_data`, `bne_rob`, `bne_taken` = 0; `add_free=1`, `bne_free=1`.
- Latency, ready-at-issue: issued at edge N, dispatched at edge N+1, so `cdb_valid` is high in cycle N+1..N+2.
- Dependent op:
  - Captures the tag at the edge ending the broadcast cycle and dispatches at the following edge, giving one bubble.
  - Same-cycle operand forwarding into dispatch select is not performed.
- `cdb_valid` and `bne_valid` are single-cycle pulses; back-to-back pulses are allowed.
- Flush:
  - Takes effect at the next edge and dominates issue, dispatch and capture.
  - Outputs are 0 after that edge.
- `reset` asserted mid-operation clears everything immediately, without waiting for a clock edge.
- An entry freed by dispatch at edge N is reusable for an issue at edge N+1.

## Configuration
- `ALU_SUB_EN` defined: subtype 1 computes d1 − d2.
- `ALU_SUB_EN` undefined: subtype 1 is undefined and yields 0.

## Structure
- Shared package holds:
  - op type constants (ALU=1, BNE=2);
  - subtype constants;
  - default data width 32;
  - pending-tag encoding helper (MSB = pending).
- One sub-module, `rs_operand`: a single tagged operand slot with capture from two buses. Each entry instantiates it twice.

## Test plan
- Ready-at-issue: issue ADD rob=3, d1=5, d2=7 → one cycle later `cdb_valid` with rob=3, data=12; `add_free` returns to 1.
- Pending operand:
  - Issue XOR rob=1 with q1={1,2}, d2=6.
  - Pulse `cdb2` rob=2, data=9.
  - Expect a broadcast rob=1, data=15 two edges after the pulse.
- Issue-time bypass: issue AND with q1 matching the current `cdb_rob`=4 (data=0xF) and d2=0x3C → result 0xC.
- Full station: issue 5 ALU ops with pending operands → `add_free=0` after 4; the 5th is dropped and is never broadcast.
- BNE: d1=3, d2=3 → `bne_taken=0`; d1=3, d2=4 → `bne_taken=1`, each with the correct `bne_rob`.
- Flush and reset:
  - Flush with 3 entries busy → no further broadcasts; both free flags high.
  - Async `reset` low mid-cycle → outputs are 0 before the next edge.
